// File: rtl/lsu_mem_ctrl_if.sv
// Shared access-size encoding plus the core-side and memory-side bundles of the
// load/store front-end.
package lsu_mem_ctrl_pkg;
  typedef enum logic [1:0] {
    OP_DMEM_BYTE = 2'd0,
    OP_DMEM_HALF = 2'd1,
    OP_DMEM_TRPL = 2'd2,
    OP_DMEM_WORD = 2'd3
  } op_enum_dmem_size;
endpackage

interface lsu_core_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 4
);
  import lsu_mem_ctrl_pkg::*;
  logic              lsu_valid;
  logic              lsu_wen;
  logic              lsu_zero_ex;
  op_enum_dmem_size  lsu_size;
  logic [AWIDTH-1:0] lsu_addr;
  logic [DWIDTH-1:0] lsu_wdata;
  logic              lsu_busy;
  logic              lsu_done;
  logic              lsu_fault;
  logic [DWIDTH-1:0] lsu_rdata;

  modport master (
    output lsu_valid, lsu_wen, lsu_zero_ex, lsu_size, lsu_addr, lsu_wdata,
    input  lsu_busy, lsu_done, lsu_fault, lsu_rdata
  );
  modport slave (
    input  lsu_valid, lsu_wen, lsu_zero_ex, lsu_size, lsu_addr, lsu_wdata,
    output lsu_busy, lsu_done, lsu_fault, lsu_rdata
  );
endinterface

interface lsu_dmem_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 4
);
  import lsu_mem_ctrl_pkg::*;
  logic              mem_req;
  logic              mem_wen;
  logic              mem_ren;
  logic              mem_zero_ex;
  op_enum_dmem_size  mem_size;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wr_data;
  logic [DWIDTH-1:0] mem_rd_data;

  modport master (
    output mem_req, mem_wen, mem_ren, mem_zero_ex, mem_size, mem_addr, mem_wr_data,
    input  mem_rd_data
  );
  modport slave (
    input  mem_req, mem_wen, mem_ren, mem_zero_ex, mem_size, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end: checks alignment and bounds, sequences one memory access
// per request and returns the extended read data with a one-cycle done pulse.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH       = 2**4,
  parameter int unsigned SYNC_READ   = 0,
  parameter int unsigned BOUND_CHECK = 1
) (
  input logic        clk,
  input logic        res,
  lsu_core_if.slave  core,
  lsu_dmem_if.master dmem
);
  localparam int unsigned AWIDTH = $clog2(DEPTH);
  localparam int unsigned EWIDTH = AWIDTH + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              wen_q;
  logic              mem_zx_q;
  op_enum_dmem_size  mem_size_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              busy_q, done_q, fault_q, req_q, mwen_q, ren_q;
  logic              busy_d, done_d, fault_d, req_d, mwen_d, ren_d;
  logic              accept_c, capture_c, misalign_c, oob_c, legal_c;
  logic [EWIDTH-1:0] last_c;

  // Request legality; the extra address bit keeps the last-byte sum from wrapping.
  always_comb begin
    misalign_c = 1'b0;
    case (core.lsu_size)
      OP_DMEM_HALF:               misalign_c = core.lsu_addr[0];
      OP_DMEM_TRPL, OP_DMEM_WORD: misalign_c = |core.lsu_addr[1:0];
      default:                    misalign_c = 1'b0;
    endcase
    last_c  = EWIDTH'(core.lsu_addr) + EWIDTH'(core.lsu_size);
    oob_c   = (BOUND_CHECK != 0) && (last_c > EWIDTH'(DEPTH - 1));
    legal_c = !misalign_c && !oob_c;
  end

  assign accept_c  = (state_q == ST_IDLE) && core.lsu_valid;
  assign capture_c = ((state_q == ST_ACCESS) && !wen_q && (SYNC_READ == 0)) ||
                     (state_q == ST_WAIT);

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (core.lsu_valid) state_d = legal_c ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_d = (!wen_q && (SYNC_READ != 0)) ? ST_WAIT : ST_RESP;
      ST_WAIT:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_RESP);
    // RESP straight out of IDLE only happens for a rejected request.
    fault_d = (state_q == ST_IDLE) && (state_d == ST_RESP);
    req_d   = (state_d == ST_ACCESS);
    mwen_d  = req_d && core.lsu_wen;
    ren_d   = req_d && !core.lsu_wen;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      req_q       <= 1'b0;
      mwen_q      <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      mem_zx_q    <= 1'b0;
      mem_size_q  <= OP_DMEM_WORD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      req_q   <= req_d;
      mwen_q  <= mwen_d;
      ren_q   <= ren_d;
      // Captured request doubles as the held memory-side address/size/data.
      if (accept_c) begin
        wen_q       <= core.lsu_wen;
        mem_zx_q    <= core.lsu_zero_ex;
        mem_size_q  <= core.lsu_size;
        mem_addr_q  <= core.lsu_addr;
        mem_wdata_q <= core.lsu_wdata;
      end
      if (capture_c) rdata_q <= dmem.mem_rd_data;
    end
  end

  assign core.lsu_busy  = busy_q;
  assign core.lsu_done  = done_q;
  assign core.lsu_fault = fault_q;
  assign core.lsu_rdata = rdata_q;

  // Strobes are gated by reset so a store caught mid-access never commits.
  assign dmem.mem_req     = req_q && !res;
  assign dmem.mem_wen     = mwen_q && !res;
  assign dmem.mem_ren     = ren_q;
  assign dmem.mem_zero_ex = mem_zx_q;
  assign dmem.mem_size    = mem_size_q;
  assign dmem.mem_addr    = mem_addr_q;
  assign dmem.mem_wr_data = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: an async-read and a sync-read instance, each with its
// own byte-array memory, driven in lockstep and checked against a byte-level model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 8 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res, mem_clr;
  logic [1:0]       valid;
  logic             t_wen, t_zx;
  op_enum_dmem_size t_size;
  logic [AW-1:0]    t_addr;
  logic [DW-1:0]    t_wdata;

  logic [1:0]    busy_w, done_w, fault_w, req_w, mwen_w, ren_w, mzx_w;
  logic [1:0]    msize_w [2];
  logic [AW-1:0] maddr_w [2];
  logic [DW-1:0] rdata_w [2];
  logic [DW-1:0] mwd_w   [2];
  logic [CW-1:0] mem_w   [2];

  int checks = 0;
  int errors = 0;
  logic [7:0]    ref_mem [DEPTH];
  logic [DW-1:0] exp_rd;

  // Fill bytes at and above nb with the zero or sign extension of byte nb-1.
  function automatic logic [DW-1:0] fill_ext(input logic [DW-1:0] raw, input int nb, input logic zx);
    logic [DW-1:0] v;
    v = raw;
    for (int b = 0; b < 4; b++)
      if (b >= nb) v[8*b +: 8] = (!zx && raw[8*nb-1]) ? 8'hFF : 8'h00;
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    lsu_core_if #(.DWIDTH(DW), .AWIDTH(AW)) cif ();
    lsu_dmem_if #(.DWIDTH(DW), .AWIDTH(AW)) mif ();
    logic [7:0]    mem [DEPTH];
    logic [DW-1:0] raw_c, raw_q;
    logic [CW-1:0] flat;

    lsu_mem_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH), .SYNC_READ(g), .BOUND_CHECK(1)) dut (
      .clk (clk),
      .res (res),
      .core(cif),
      .dmem(mif)
    );

    assign cif.lsu_valid   = valid[g];
    assign cif.lsu_wen     = t_wen;
    assign cif.lsu_zero_ex = t_zx;
    assign cif.lsu_size    = t_size;
    assign cif.lsu_addr    = t_addr;
    assign cif.lsu_wdata   = t_wdata;

    always_comb begin
      for (int b = 0; b < 4; b++) raw_c[8*b +: 8] = mem[AW'(mif.mem_addr + AW'(b))];
      for (int i = 0; i < int'(DEPTH); i++) flat[8*i +: 8] = mem[i];
      mif.mem_rd_data = fill_ext((g == 1) ? raw_q : raw_c, int'(mif.mem_size) + 1, mif.mem_zero_ex);
    end

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
      end else if (mif.mem_req && mif.mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (b <= int'(mif.mem_size)) mem[AW'(mif.mem_addr + AW'(b))] <= mif.mem_wr_data[8*b +: 8];
      end
      if (mif.mem_req && mif.mem_ren) raw_q <= raw_c;
    end

    assign busy_w[g]  = cif.lsu_busy;
    assign done_w[g]  = cif.lsu_done;
    assign fault_w[g] = cif.lsu_fault;
    assign rdata_w[g] = cif.lsu_rdata;
    assign req_w[g]   = mif.mem_req;
    assign mwen_w[g]  = mif.mem_wen;
    assign ren_w[g]   = mif.mem_ren;
    assign mzx_w[g]   = mif.mem_zero_ex;
    assign msize_w[g] = mif.mem_size;
    assign maddr_w[g] = mif.mem_addr;
    assign mwd_w[g]   = mif.mem_wr_data;
    assign mem_w[g]   = flat;
  end

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] ref_flat();
    logic [CW-1:0] v;
    for (int i = 0; i < int'(DEPTH); i++) v[8*i +: 8] = ref_mem[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_load(input int a, input int nb, input logic zx);
    logic [DW-1:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = ref_mem[a + b];
    return fill_ext(v, nb, zx);
  endfunction

  function automatic logic ref_fault(input int a, input op_enum_dmem_size s);
    int nb, al;
    nb = int'(s) + 1;
    al = (s == OP_DMEM_BYTE) ? 1 : (s == OP_DMEM_HALF) ? 2 : 4;
    return ((a % al) != 0) || (a + nb > int'(DEPTH));
  endfunction

  // One request on both instances; samples on falling edges, n=1 is the cycle after accept.
  task automatic do_op(input string nm, input logic wen, input logic zx, input op_enum_dmem_size sz,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic ef,
                       input logic [DW-1:0] erd);
    int lat [2]; int reqs [2]; int dones [2]; int elat;
    logic [DW-1:0] rd [2];
    logic [1:0] fl;
    fl = 2'b00;
    for (int g = 0; g < 2; g++) begin lat[g] = 0; reqs[g] = 0; dones[g] = 0; rd[g] = '0; end
    @(negedge clk);
    t_wen = wen; t_zx = zx; t_size = sz; t_addr = a; t_wdata = wd; valid = 2'b11;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        reqs[g] += int'(req_w[g]);
        if (done_w[g]) begin
          dones[g]++;
          if (dones[g] == 1) begin lat[g] = n; rd[g] = rdata_w[g]; fl[g] = fault_w[g]; end
        end
        if (n == 1 && !ef) begin
          chk($sformatf("%s[%0d] access_wen", nm, g), CW'(mwen_w[g]), CW'(wen));
          chk($sformatf("%s[%0d] access_ren", nm, g), CW'(ren_w[g]), CW'(!wen));
          chk($sformatf("%s[%0d] access_addr", nm, g), CW'(maddr_w[g]), CW'(a));
          chk($sformatf("%s[%0d] access_size", nm, g), CW'(msize_w[g]), CW'(sz));
          if (wen) chk($sformatf("%s[%0d] access_wdata", nm, g), CW'(mwd_w[g]), CW'(wd));
          else     chk($sformatf("%s[%0d] access_zx", nm, g), CW'(mzx_w[g]), CW'(zx));
        end
        if (n == 2 && g == 1 && !wen && !ef) begin
          chk($sformatf("%s wait_req", nm), CW'(req_w[1]), CW'(0));
          chk($sformatf("%s wait_ren", nm), CW'(ren_w[1]), CW'(0));
          chk($sformatf("%s wait_size", nm), CW'(msize_w[1]), CW'(sz));
          chk($sformatf("%s wait_addr", nm), CW'(maddr_w[1]), CW'(a));
        end
      end
      if (n == 1) valid = 2'b00;
    end
    if (wen && !ef)
      for (int b = 0; b < 4; b++) if (b <= int'(sz)) ref_mem[AW'(a + AW'(b))] = wd[8*b +: 8];
    for (int g = 0; g < 2; g++) begin
      elat = ef ? 1 : (!wen && g == 1) ? 3 : 2;
      chk($sformatf("%s[%0d] latency", nm, g), CW'(lat[g]), CW'(elat));
      chk($sformatf("%s[%0d] done_pulses", nm, g), CW'(dones[g]), CW'(1));
      chk($sformatf("%s[%0d] fault", nm, g), CW'(fl[g]), CW'(ef));
      chk($sformatf("%s[%0d] req_cycles", nm, g), CW'(reqs[g]), CW'(ef ? 0 : 1));
      chk($sformatf("%s[%0d] rdata", nm, g), CW'(rd[g]), CW'(erd));
      chk($sformatf("%s[%0d] busy_after", nm, g), CW'(busy_w[g]), CW'(0));
      chk($sformatf("%s[%0d] memory", nm, g), mem_w[g], ref_flat());
    end
    exp_rd = erd;
  endtask

  typedef struct {
    logic             wen;
    logic             zx;
    op_enum_dmem_size sz;
    logic [AW-1:0]    a;
    logic [DW-1:0]    wd;
    logic             ef;
    logic [DW-1:0]    erd;
  } vec_t;

  vec_t             tbl [12];
  int               da [2]; int ra [2]; int dn [2];
  logic [DW-1:0]    rda [2];
  logic             r_w, r_z, r_f;
  op_enum_dmem_size r_s;
  logic [AW-1:0]    r_a;
  logic [DW-1:0]    r_d, r_e;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, OP_DMEM_WORD, 4'h4, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b0, OP_DMEM_WORD, 4'h4, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b0, OP_DMEM_BYTE, 4'h7, 32'h0,        1'b0, 32'hFFFFFFDE};
    tbl[3]  = '{1'b0, 1'b1, OP_DMEM_HALF, 4'h6, 32'h0,        1'b0, 32'h0000DEAD};
    tbl[4]  = '{1'b0, 1'b0, OP_DMEM_HALF, 4'h5, 32'h0,        1'b1, 32'h0000DEAD};
    tbl[5]  = '{1'b1, 1'b0, OP_DMEM_WORD, 4'h6, 32'h55555555, 1'b1, 32'h0000DEAD};
    tbl[6]  = '{1'b0, 1'b0, OP_DMEM_WORD, 4'hE, 32'h0,        1'b1, 32'h0000DEAD};
    tbl[7]  = '{1'b1, 1'b0, OP_DMEM_TRPL, 4'h8, 32'h11ABCDEF, 1'b0, 32'h0000DEAD};
    tbl[8]  = '{1'b0, 1'b0, OP_DMEM_TRPL, 4'h8, 32'h0,        1'b0, 32'hFFABCDEF};
    tbl[9]  = '{1'b0, 1'b1, OP_DMEM_WORD, 4'h8, 32'h0,        1'b0, 32'h00ABCDEF};
    tbl[10] = '{1'b0, 1'b1, OP_DMEM_BYTE, 4'hF, 32'h0,        1'b0, 32'h00000000};
    tbl[11] = '{1'b0, 1'b0, OP_DMEM_HALF, 4'h7, 32'h0,        1'b1, 32'h00000000};

    res = 1'b1; mem_clr = 1'b1; valid = 2'b00;
    t_wen = 1'b0; t_zx = 1'b0; t_size = OP_DMEM_BYTE; t_addr = '0; t_wdata = '0;
    exp_rd = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset[%0d] busy", g), CW'(busy_w[g]), CW'(0));
      chk($sformatf("reset[%0d] done", g), CW'(done_w[g]), CW'(0));
      chk($sformatf("reset[%0d] fault", g), CW'(fault_w[g]), CW'(0));
      chk($sformatf("reset[%0d] strobes", g), CW'({req_w[g], mwen_w[g], ren_w[g]}), CW'(0));
      chk($sformatf("reset[%0d] rdata", g), CW'(rdata_w[g]), CW'(0));
      chk($sformatf("reset[%0d] addr", g), CW'(maddr_w[g]), CW'(0));
      chk($sformatf("reset[%0d] wr_data", g), CW'(mwd_w[g]), CW'(0));
      chk($sformatf("reset[%0d] size", g), CW'(msize_w[g]), CW'(OP_DMEM_WORD));
      chk($sformatf("reset[%0d] zero_ex", g), CW'(mzx_w[g]), CW'(0));
    end
    res = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), tbl[i].wen, tbl[i].zx, tbl[i].sz, tbl[i].a, tbl[i].wd,
            tbl[i].ef, tbl[i].erd);

    // Reset pulsed during the ACCESS cycle of a store: no commit, no done.
    @(negedge clk);
    t_wen = 1'b1; t_zx = 1'b0; t_size = OP_DMEM_WORD; t_addr = 4'h8; t_wdata = 32'h12345678;
    valid = 2'b11;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("rst_mid[%0d] in_access", g), CW'(req_w[g]), CW'(1));
    valid = 2'b00; res = 1'b1;
    #1;
    for (int g = 0; g < 2; g++)
      chk($sformatf("rst_mid[%0d] gated", g), CW'({req_w[g], mwen_w[g]}), CW'(0));
    @(negedge clk);
    res = 1'b0;
    for (int g = 0; g < 2; g++) begin dn[g] = int'(done_w[g]); chk($sformatf("rst_mid[%0d] idle", g), CW'(busy_w[g]), CW'(0)); end
    repeat (4) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) dn[g] += int'(done_w[g]);
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_mid[%0d] no_done", g), CW'(dn[g]), CW'(0));
      chk($sformatf("rst_mid[%0d] memory", g), mem_w[g], ref_flat());
    end
    do_op("rst_reload", 1'b0, 1'b1, OP_DMEM_WORD, 4'h8, 32'h0, 1'b0, ref_load(8, 4, 1'b1));

    // Request held while busy with a different address: ignored until IDLE.
    @(negedge clk);
    t_wen = 1'b0; t_zx = 1'b0; t_size = OP_DMEM_WORD; t_addr = 4'h4; t_wdata = '0; valid = 2'b11;
    for (int g = 0; g < 2; g++) begin da[g] = 0; ra[g] = 0; dn[g] = 0; rda[g] = '0; end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (da[g] == 0) ra[g] += int'(req_w[g] && (maddr_w[g] == 4'h4));
        if (done_w[g]) begin
          dn[g]++;
          if (da[g] == 0) begin da[g] = n; rda[g] = rdata_w[g]; end
        end else if (da[g] != 0 && n == da[g] + 1) begin
          chk($sformatf("held[%0d] idle_gap", g), CW'(busy_w[g]), CW'(0));
        end else if (da[g] != 0 && n == da[g] + 2) begin
          chk($sformatf("held[%0d] second_accept", g), CW'({busy_w[g], req_w[g], mwen_w[g]}), CW'(3'b111));
          chk($sformatf("held[%0d] second_addr", g), CW'(maddr_w[g]), CW'(0));
          valid[g] = 1'b0;
        end
      end
      if (n == 1) begin t_wen = 1'b1; t_addr = 4'h0; t_wdata = 32'hCAFEF00D; end
    end
    valid = 2'b00;
    for (int b = 0; b < 4; b++) ref_mem[b] = 8'(32'hCAFEF00D >> (8 * b));
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("held[%0d] first_latency", g), CW'(da[g]), CW'(g == 1 ? 3 : 2));
      chk($sformatf("held[%0d] first_rdata", g), CW'(rda[g]), CW'(32'hDEADBEEF));
      chk($sformatf("held[%0d] first_reqs", g), CW'(ra[g]), CW'(1));
      chk($sformatf("held[%0d] done_pulses", g), CW'(dn[g]), CW'(2));
      chk($sformatf("held[%0d] memory", g), mem_w[g], ref_flat());
    end
    exp_rd = 32'hDEADBEEF;

    for (int i = 0; i < 40; i++) begin
      r_w = 1'($urandom_range(0, 1));
      r_z = 1'($urandom_range(0, 1));
      r_s = op_enum_dmem_size'($urandom_range(0, 3));
      r_a = AW'($urandom_range(0, DEPTH - 1));
      r_d = $urandom;
      r_f = ref_fault(int'(r_a), r_s);
      r_e = (!r_w && !r_f) ? ref_load(int'(r_a), int'(r_s) + 1, r_z) : exp_rd;
      do_op($sformatf("rnd%0d", i), r_w, r_z, r_s, r_a, r_d, r_f, r_e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store front-end sitting directly upstream of the data memory. It accepts one load or store at a time from the core datapath over a valid/busy/done handshake.
- It checks alignment and bounds, then drives the memory's req/wen/ren/mem_size/addr/wr_data/zero_ex pins for the correct number of cycles.
- It captures the already-extended read data and returns it to the core with a one-cycle done pulse.
- It hides the difference between async-read and sync-read memory builds.

Parameters:
- DWIDTH, 32, data word width (core and memory side).
- DEPTH, 2**4, memory depth in bytes; must match the memory instance.
- SYNC_READ, 0, 0 = memory reads combinationally; 1 = memory read data valid one clock after req.
- BOUND_CHECK, 1, 1 = fault accesses whose last byte exceeds DEPTH-1; 0 = no bounds check.

Ports:
- clk  in  1  single clock; memory wclk and rclk are tied to it.
- res  in  1  synchronous active-high reset.
- lsu_valid  in  1  request strobe; sampled only in IDLE.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_zero_ex  in  1  load is zero-extended (1) or sign-extended (0).
- lsu_size  in  op_enum_dmem_size  BYTE/HALF/TRPL/WORD.
- lsu_addr  in  $clog2(DEPTH)  byte address.
- lsu_wdata  in  DWIDTH  store data.
- lsu_busy  out  1  high in every state except IDLE.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_fault  out  1  valid with lsu_done: request rejected, memory untouched.
- lsu_rdata  out  DWIDTH  load result; valid with lsu_done, held until next done.
- mem_req, mem_wen, mem_ren  out  1  memory strobes.
- mem_zero_ex  out  1  to memory.
- mem_size  out  op_enum_dmem_size  to memory.
- mem_addr  out  $clog2(DEPTH)  to memory.
- mem_wr_data  out  DWIDTH  to memory.
- mem_rd_data  in  DWIDTH  extended read data from memory.

Behaviour:
- Reset: state IDLE. lsu_busy, lsu_done, lsu_fault, mem_req, mem_wen, mem_ren = 0. lsu_rdata, mem_addr, mem_wr_data = 0. mem_size = OP_DMEM_WORD. mem_zero_ex = 0.
- FSM states:
  - IDLE -> ACCESS on lsu_valid with a legal request.
  - IDLE -> RESP on lsu_valid with an illegal request.
  - ACCESS -> WAIT if load and SYNC_READ=1; otherwise ACCESS -> RESP.
  - WAIT -> RESP.
  - RESP -> IDLE.
- Acceptance: in IDLE with lsu_valid=1, lsu_wen, lsu_zero_ex, lsu_size, lsu_addr and lsu_wdata are registered. Inputs are ignored in all other states; there is no queueing.
- Alignment check:
  - HALF needs addr[0]=0.
  - WORD and TRPL need addr[1:0]=0.
  - BYTE is always aligned.
- Bounds check (BOUND_CHECK=1): fault if addr + nbytes - 1 > DEPTH-1, with nbytes = 1/2/3/4. Compute with one extra bit so it does not wrap.
- Fault path: no mem_req is ever asserted. In RESP, lsu_done=1 and lsu_fault=1, and lsu_rdata is unchanged.
- ACCESS (1 cycle):
  - mem_req=1, mem_wen=lsu_wen, mem_ren=!lsu_wen.
  - mem_addr, mem_size, mem_zero_ex and mem_wr_data driven from the registered values.
  - A store commits at the clk edge ending ACCESS.
  - Async load: mem_rd_data is captured into lsu_rdata at that same edge.
- WAIT (sync loads only):
  - mem_req = mem_ren = 0.
  - mem_addr, mem_size and mem_zero_ex stay held, because the memory's extension logic is combinational on mem_size.
  - mem_rd_data is captured at the edge ending WAIT.
- RESP: lsu_done=1 for exactly one cycle, lsu_fault=0 on the non-fault path.
- Latency, counted from the accept edge to the cycle lsu_done is high:
  - Store: 2 cycles.
  - Async load: 2 cycles.
  - Sync load: 3 cycles.
  - Fault: 1 cycle.
  - Throughput: one op per latency+1 cycles; a new request is accepted only when back in IDLE.
- mem_* strobes are registered (Moore) outputs. They are 0 in IDLE/RESP and during reset.
- Reset mid-operation: res=1 in any state forces IDLE at that edge, and mem_req/mem_wen are gated by !res in the same cycle. A store in ACCESS while res=1 must not commit, and no lsu_done is produced for an aborted op.
- lsu_valid held high across lsu_done is treated as a new request, accepted in the cycle after RESP.

Test Plan:
- Store WORD 0xDEADBEEF @0x4, then load WORD @0x4, SYNC_READ=0 -> each lsu_done 2 cycles after accept; lsu_rdata=0xDEADBEEF, lsu_fault=0; mem_req high exactly 1 cycle per op.
- Same sequence with SYNC_READ=1 -> store done at +2, load done at +3, lsu_rdata=0xDEADBEEF; mem_size held WORD through WAIT.
- After the above: load BYTE @0x7, zero_ex=0 -> 0xFFFFFFDE. Load HALF @0x6, zero_ex=1 -> 0x0000DEAD.
- HALF @0x5, WORD @0x6, and WORD @0xE with DEPTH=16 -> each gives lsu_done=1, lsu_fault=1 one cycle after accept; mem_req never asserted; memory contents unchanged; previous lsu_rdata retained.
- Store WORD 0x12345678 @0x8 with res pulsed high in the ACCESS cycle -> FSM is IDLE next cycle, no lsu_done, and a subsequent load @0x8 returns the pre-reset memory value.
- lsu_valid asserted while lsu_busy=1 with a different address -> ignored; only the original op completes, and the second op is accepted only once the FSM is back in IDLE.
